div_sc_mem_wr: RTL and testbench
================================

Name: div_sc_mem_wr

Overview:
- Builds the histogram-equalisation lookup table that the image-mapping controller consumes; sits directly upstream of it.
- Reads the cumulative histogram (CDF) memory: 64 lines x 128 bits, 4 entries of 32 bits per line, 256 grey levels.
- Computes map[e] = floor((cdf[e]-cdf_min)*255 / (TOTAL_PIX-cdf_min)) and writes the result into scratch memory in the same slot layout.
- Pulses div_sc_mem_wt_done when the whole table is written.

Parameters:
- TOTAL_PIX, 1024, pixel count of the image (32x32); fits in 16 bits.
- RD_LAT, 2, CDF memory read latency in cycles.
- NUM_W, 20, divider numerator width.
- DEN_W, 16, divider denominator width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cdf_mem_wt_done  in  1  start pulse from the histogram/CDF stage
- cdf_mem_rd_data  in  128  CDF line; entry k of the line is bits [32k+31:32k]
- cdf_mem_rd_addr  out  16  CDF line address, 0..63
- sc_mem_wt_addr  out  16  scratch line address, 0..63
- sc_mem_wt_data  out  128  four map entries, each zero-extended 8-bit value in its 32-bit slot
- sc_mem_wt_en  out  1  scratch write strobe
- div_sc_mem_wt_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high. All outputs go to 0, FSM to IDLE, divider cleared. Reset mid-operation aborts with no done pulse and no further writes.
- Entry mapping: entry e lives in line e>>2, slot e&3. Output uses an identical layout so the consumer indexes it as (value>>2, value&3).
- Read timing: the address is registered in a RD state. Data is sampled exactly RD_LAT cycles after the address appears; the intervening cycles are wait states.
- FSM states:
  - IDLE: waits for cdf_mem_wt_done. A start pulse in any other state is ignored.
  - MIN_RD -> MIN_WAIT(xRD_LAT) -> MIN_CHK: finds cdf_min. Lines are scanned from 0 upward, slots in order 0..3. cdf_min = first nonzero entry.
    - A line with a nonzero entry goes to LINE_RD with line=0. An all-zero line increments the address.
    - If line 63 is all zero, cdf_min=0.
  - LINE_RD -> LINE_WAIT(xRD_LAT) -> latch the 128-bit line; slot=0.
  - DIV_START: form num=(cdf-cdf_min)*255 (NUM_W) and den=TOTAL_PIX-cdf_min, then pulse the divider start. Special cases bypass the divider straight to PACK:
    - cdf < cdf_min (incl. 0): result 0.
    - den == 0: result 255.
  - DIV_WAIT: wait for div_done; quotient[7:0] is placed into slot. If the quotient is > 255, clamp to 255.
  - PACK: slot++. Slot < 3 returns to DIV_START; otherwise go to WRITE.
  - WRITE: sc_mem_wt_addr=line, sc_mem_wt_data=packed line, sc_mem_wt_en=1 for exactly one cycle.
  - WT_IDLE1, WT_IDLE2: sc_mem_wt_en=0, data and address held. Then line < 63 does line++ -> LINE_RD; line == 63 -> DONE.
  - DONE: div_sc_mem_wt_done=1 for one cycle -> IDLE.
- Width rules:
  - All subtraction is unsigned, guarded by the cdf >= cdf_min check.
  - Upper 24 bits of every slot are written 0.
- Divider: restoring, one quotient bit per cycle. Fixed latency NUM_W cycles from start to done, with done as a one-cycle pulse.

Decomposition:
- Shared package (img_pkg):
  - NUM_LINES=64, SLOTS_PER_LINE=4, SLOT_W=32, PIX_W=8, MAX_LEVEL=255.
  - FSM state encoding localparams.
  - Memory address width 16.
- Sub-module seq_divider: ports clk, reset, start, num[NUM_W], den[DEN_W], quo[NUM_W], rem[DEN_W], done. This is the only natural split.

Test Plan:
- Uniform CDF, cdf[e]=4*(e+1), start pulse -> cdf_min=4. Slots read map[0]=0, map[127]=127, map[255]=255, map[1]=floor(4*255/1020)=1. Exactly 64 writes at addresses 0..63, then one done pulse.
- Single-level image, cdf[e]=0 for e<100 and 1024 for e>=100 -> map[0..99]=0, map[100..255]=255 via the den==0 path. The divider is never started.
- Sparse CDF with entries zero until line 5, slot 2 (=37) -> cdf_min=37, map[22]=0, map[255]=255. The scan reads exactly 6 lines before LINE_RD.
- Reset asserted during DIV_WAIT of line 30 -> next cycle all outputs 0, no done. A fresh start gives a correct full table.
- Second cdf_mem_wt_done pulse during line 10 -> ignored. Exactly one done pulse, write count 64.
- seq_divider standalone: 260100/1020 -> 255; 129540/1020 -> 127 rem 0; 5/7 -> 0 rem 5. Done asserts NUM_W cycles after start.

Source files
------------

// File: rtl/div_sc_mem_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_sc_mem_wr_pkg
// Purpose  : Shared image-pipeline definitions for the histogram-equalisation
//            LUT builder: memory geometry, pixel widths, FSM state encoding
//            and a slot-extraction helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package div_sc_mem_wr_pkg;

    localparam int NUM_LINES      = 64;
    localparam int SLOTS_PER_LINE = 4;
    localparam int SLOT_W         = 32;
    localparam int PIX_W          = 8;
    localparam int MAX_LEVEL      = 255;
    localparam int ADDR_W         = 16;
    localparam int LINE_W         = SLOTS_PER_LINE * SLOT_W;
    localparam int LINE_IDX_W     = 6;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_MIN_RD    = 4'd1;
    localparam logic [3:0] ST_MIN_WAIT  = 4'd2;
    localparam logic [3:0] ST_MIN_CHK   = 4'd3;
    localparam logic [3:0] ST_LINE_RD   = 4'd4;
    localparam logic [3:0] ST_LINE_WAIT = 4'd5;
    localparam logic [3:0] ST_LINE_CAP  = 4'd6;
    localparam logic [3:0] ST_DIV_START = 4'd7;
    localparam logic [3:0] ST_DIV_WAIT  = 4'd8;
    localparam logic [3:0] ST_PACK      = 4'd9;
    localparam logic [3:0] ST_WRITE     = 4'd10;
    localparam logic [3:0] ST_WT_IDLE1  = 4'd11;
    localparam logic [3:0] ST_WT_IDLE2  = 4'd12;
    localparam logic [3:0] ST_DONE      = 4'd13;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_MIN_RD    = ST_MIN_RD,
        S_MIN_WAIT  = ST_MIN_WAIT,
        S_MIN_CHK   = ST_MIN_CHK,
        S_LINE_RD   = ST_LINE_RD,
        S_LINE_WAIT = ST_LINE_WAIT,
        S_LINE_CAP  = ST_LINE_CAP,
        S_DIV_START = ST_DIV_START,
        S_DIV_WAIT  = ST_DIV_WAIT,
        S_PACK      = ST_PACK,
        S_WRITE     = ST_WRITE,
        S_WT_IDLE1  = ST_WT_IDLE1,
        S_WT_IDLE2  = ST_WT_IDLE2,
        S_DONE      = ST_DONE
    } state_t;

    // Entry k of a memory line occupies bits [32k+31:32k].
    function automatic logic [SLOT_W-1:0] get_slot(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        slot);
        return line[{slot, 5'b00000} +: SLOT_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sc_mem_wr_if.sv
`default_nettype none
// ============================================================================
// Module   : div_sc_mem_wr_if
// Purpose  : Bus bundle between the LUT builder, the CDF memory (read side),
//            the scratch memory (write side) and the neighbouring stages.
// Signals  : cdf_mem_wt_done    start pulse from the CDF stage
//            cdf_mem_rd_data    128-bit CDF line
//            cdf_mem_rd_addr    CDF line address
//            sc_mem_wt_addr     scratch line address
//            sc_mem_wt_data     four packed map entries
//            sc_mem_wt_en       scratch write strobe
//            div_sc_mem_wt_done completion pulse
// Modports : master = LUT builder, slave = memories / environment
// Revision : 1.0  initial release
// ============================================================================
interface div_sc_mem_wr_if;
    import div_sc_mem_wr_pkg::*;

    logic               cdf_mem_wt_done;
    logic [LINE_W-1:0]  cdf_mem_rd_data;
    logic [ADDR_W-1:0]  cdf_mem_rd_addr;
    logic [ADDR_W-1:0]  sc_mem_wt_addr;
    logic [LINE_W-1:0]  sc_mem_wt_data;
    logic               sc_mem_wt_en;
    logic               div_sc_mem_wt_done;

    modport master (
        input  cdf_mem_wt_done,
        input  cdf_mem_rd_data,
        output cdf_mem_rd_addr,
        output sc_mem_wt_addr,
        output sc_mem_wt_data,
        output sc_mem_wt_en,
        output div_sc_mem_wt_done
    );

    modport slave (
        output cdf_mem_wt_done,
        output cdf_mem_rd_data,
        input  cdf_mem_rd_addr,
        input  sc_mem_wt_addr,
        input  sc_mem_wt_data,
        input  sc_mem_wt_en,
        input  div_sc_mem_wt_done
    );

endinterface
`default_nettype wire

// File: rtl/div_sc_mem_wr_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Restoring unsigned divider, one quotient bit per cycle.
//            done pulses exactly NUM_W cycles after start is sampled.
// Ports    : clk, reset (sync, active-high)
//            start  load operands and begin
//            num    dividend [NUM_W]
//            den    divisor  [DEN_W]
//            quo    quotient [NUM_W], valid while done
//            rem    remainder [DEN_W], valid while done
//            done   one-cycle completion pulse
// Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic [NUM_W-1:0] num,
    input  wire logic [DEN_W-1:0] den,
    output logic      [NUM_W-1:0] quo,
    output logic      [DEN_W-1:0] rem,
    output logic                  done
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] r_quo;
    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    // Partial remainder shifted left with the next dividend bit; the
    // dividend register doubles as the quotient shift register.
    logic [DEN_W:0] w_part;
    logic [DEN_W:0] w_diff;
    logic           w_ge;

    assign w_part = {r_rem, r_quo[NUM_W-1]};
    assign w_diff = w_part - {1'b0, r_den};
    assign w_ge   = (w_part >= {1'b0, r_den});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_quo  <= num;
                r_rem  <= '0;
                r_den  <= den;
                r_cnt  <= CNT_W'(NUM_W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_quo <= {r_quo[NUM_W-2:0], w_ge};
                // When the trial subtraction fails, w_part < den so its MSB is 0.
                r_rem <= w_ge ? w_diff[DEN_W-1:0] : w_part[DEN_W-1:0];
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    logic w_unused_diff_msb;
    assign w_unused_diff_msb = w_diff[DEN_W];

    assign quo  = r_quo;
    assign rem  = r_rem;
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/div_sc_mem_wr.sv
`default_nettype none
// ============================================================================
// Module   : div_sc_mem_wr
// Purpose  : Builds the histogram-equalisation LUT. Scans the CDF memory for
//            the first nonzero entry (cdf_min), then for every grey level e
//            computes floor((cdf[e]-cdf_min)*255/(TOTAL_PIX-cdf_min)) and
//            writes the 8-bit results into scratch memory, four per line, in
//            the same line/slot layout as the CDF. Pulses done at the end.
// Ports    : clk    clock
//            reset  synchronous, active-high
//            bus    div_sc_mem_wr_if.master (CDF read / scratch write / start
//                   and done handshakes)
// Revision : 1.0  initial release
// ============================================================================
module div_sc_mem_wr
    import div_sc_mem_wr_pkg::*;
#(
    parameter int TOTAL_PIX = 1024,
    parameter int RD_LAT    = 2,
    parameter int NUM_W     = 20,
    parameter int DEN_W     = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    div_sc_mem_wr_if.master bus
);

    localparam logic [LINE_IDX_W-1:0] c_LAST_LINE = LINE_IDX_W'(NUM_LINES - 1);
    localparam logic [3:0]            c_WAIT_LAST = 4'(RD_LAT - 1);
    localparam logic [SLOT_W-1:0]     c_TOTAL     = SLOT_W'(TOTAL_PIX);
    localparam logic [SLOT_W-1:0]     c_MAX_LEVEL = SLOT_W'(MAX_LEVEL);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [LINE_IDX_W-1:0] r_line;
    logic [1:0]            r_slot;
    logic [3:0]            r_wcnt;
    logic [SLOT_W-1:0]     r_cdf_min;
    logic [LINE_W-1:0]     r_line_data;
    logic [LINE_W-1:0]     r_pack;

    logic [ADDR_W-1:0]     r_rd_addr;
    logic [ADDR_W-1:0]     r_wt_addr;
    logic [LINE_W-1:0]     r_wt_data;
    logic                  r_wt_en;
    logic                  r_done;

    // ------------------------------------------------------------------
    // cdf_min search: lowest nonzero slot of the line currently on the bus
    // ------------------------------------------------------------------
    logic              w_found;
    logic [SLOT_W-1:0] w_first;

    always_comb begin
        w_found = 1'b0;
        w_first = '0;
        for (int k = SLOTS_PER_LINE - 1; k >= 0; k--) begin
            if (bus.cdf_mem_rd_data[k*SLOT_W +: SLOT_W] != '0) begin
                w_found = 1'b1;
                w_first = bus.cdf_mem_rd_data[k*SLOT_W +: SLOT_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-entry arithmetic
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] w_cdf;
    logic [SLOT_W-1:0] w_diff;
    logic [SLOT_W-1:0] w_prod;
    logic [SLOT_W-1:0] w_den_full;
    logic [NUM_W-1:0]  w_num;
    logic [DEN_W-1:0]  w_den;
    logic              w_below;
    logic              w_den_zero;
    logic              w_bypass;
    logic              w_div_start;
    logic [PIX_W-1:0]  w_bypass_val;
    logic [PIX_W-1:0]  w_quo_val;

    logic [NUM_W-1:0]  w_quo;
    logic [DEN_W-1:0]  w_rem;
    logic              w_div_done;

    assign w_cdf      = get_slot(r_line_data, r_slot);
    // Levels below cdf_min (zero included) map to black; this check also
    // keeps the unsigned subtraction below from wrapping.
    assign w_below    = (w_cdf == '0) || (w_cdf < r_cdf_min);
    assign w_diff     = w_cdf - r_cdf_min;
    assign w_prod     = w_diff * c_MAX_LEVEL;
    assign w_num      = w_prod[NUM_W-1:0];
    assign w_den_full = c_TOTAL - r_cdf_min;
    assign w_den      = w_den_full[DEN_W-1:0];
    // den == 0 means every pixel sits at one level: map it to white.
    assign w_den_zero = (w_den == '0);
    assign w_bypass   = w_below || w_den_zero;
    assign w_div_start = (r_state == S_DIV_START) && !w_bypass;
    assign w_bypass_val = w_below ? PIX_W'(0) : PIX_W'(MAX_LEVEL);
    assign w_quo_val    = (w_quo > NUM_W'(MAX_LEVEL)) ? PIX_W'(MAX_LEVEL) : w_quo[PIX_W-1:0];

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (w_div_start),
        .num   (w_num),
        .den   (w_den),
        .quo   (w_quo),
        .rem   (w_rem),
        .done  (w_div_done)
    );

    logic w_unused_bits;
    assign w_unused_bits = ^{w_prod[SLOT_W-1:NUM_W], w_den_full[SLOT_W-1:DEN_W], w_rem};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (bus.cdf_mem_wt_done) w_state_nxt = S_MIN_RD;
            S_MIN_RD:    w_state_nxt = S_MIN_WAIT;
            S_MIN_WAIT:  if (r_wcnt == c_WAIT_LAST) w_state_nxt = S_MIN_CHK;
            S_MIN_CHK:   w_state_nxt = (w_found || r_line == c_LAST_LINE) ? S_LINE_RD : S_MIN_RD;
            S_LINE_RD:   w_state_nxt = S_LINE_WAIT;
            S_LINE_WAIT: if (r_wcnt == c_WAIT_LAST) w_state_nxt = S_LINE_CAP;
            S_LINE_CAP:  w_state_nxt = S_DIV_START;
            S_DIV_START: w_state_nxt = w_bypass ? S_PACK : S_DIV_WAIT;
            S_DIV_WAIT:  if (w_div_done) w_state_nxt = S_PACK;
            S_PACK:      w_state_nxt = (r_slot == 2'd3) ? S_WRITE : S_DIV_START;
            S_WRITE:     w_state_nxt = S_WT_IDLE1;
            S_WT_IDLE1:  w_state_nxt = S_WT_IDLE2;
            S_WT_IDLE2:  w_state_nxt = (r_line == c_LAST_LINE) ? S_DONE : S_LINE_RD;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line      <= '0;
            r_slot      <= '0;
            r_wcnt      <= '0;
            r_cdf_min   <= '0;
            r_line_data <= '0;
            r_pack      <= '0;
            r_rd_addr   <= '0;
            r_wt_addr   <= '0;
            r_wt_data   <= '0;
            r_wt_en     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wt_en <= (w_state_nxt == S_WRITE);
            r_done  <= (w_state_nxt == S_DONE);
            r_wcnt  <= (r_state == S_MIN_WAIT || r_state == S_LINE_WAIT) ? r_wcnt + 1'b1 : 4'd0;

            case (r_state)
                S_IDLE: begin
                    if (bus.cdf_mem_wt_done) begin
                        r_line    <= '0;
                        r_cdf_min <= '0;
                    end
                end
                S_MIN_RD, S_LINE_RD: begin
                    r_rd_addr <= ADDR_W'(r_line);
                end
                S_MIN_CHK: begin
                    if (w_found) begin
                        r_cdf_min <= w_first;
                        r_line    <= '0;
                    end else if (r_line == c_LAST_LINE) begin
                        r_cdf_min <= '0;
                        r_line    <= '0;
                    end else begin
                        r_line <= r_line + 1'b1;
                    end
                end
                S_LINE_CAP: begin
                    // RD_LAT cycles have elapsed since the address appeared.
                    r_line_data <= bus.cdf_mem_rd_data;
                    r_slot      <= '0;
                    r_pack      <= '0;
                end
                S_DIV_START: begin
                    if (w_bypass) r_pack[{r_slot, 5'b00000} +: SLOT_W] <= SLOT_W'(w_bypass_val);
                end
                S_DIV_WAIT: begin
                    if (w_div_done) r_pack[{r_slot, 5'b00000} +: SLOT_W] <= SLOT_W'(w_quo_val);
                end
                S_PACK: begin
                    r_slot <= r_slot + 1'b1;
                    if (r_slot == 2'd3) begin
                        r_wt_addr <= ADDR_W'(r_line);
                        r_wt_data <= r_pack;
                    end
                end
                S_WT_IDLE2: begin
                    if (r_line != c_LAST_LINE) r_line <= r_line + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.cdf_mem_rd_addr    = r_rd_addr;
    assign bus.sc_mem_wt_addr     = r_wt_addr;
    assign bus.sc_mem_wt_data     = r_wt_data;
    assign bus.sc_mem_wt_en       = r_wt_en;
    assign bus.div_sc_mem_wt_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_div_sc_mem_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sc_mem_wr
// Purpose  : Self-checking bench for div_sc_mem_wr and its seq_divider.
//            Expected scratch lines are computed from the CDF contents and
//            queued when a table build is started; written lines are logged
//            and compared in order once the build completes.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_sc_mem_wr;
    import div_sc_mem_wr_pkg::*;

    localparam int TOTAL_PIX = 1024;
    localparam int RD_LAT    = 2;
    localparam int NUM_W     = 20;
    localparam int DEN_W     = 16;
    localparam int LOG_N     = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    div_sc_mem_wr_if u_if ();

    div_sc_mem_wr #(
        .TOTAL_PIX (TOTAL_PIX),
        .RD_LAT    (RD_LAT),
        .NUM_W     (NUM_W),
        .DEN_W     (DEN_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    logic             sd_start;
    logic [NUM_W-1:0] sd_num;
    logic [DEN_W-1:0] sd_den;
    logic [NUM_W-1:0] sd_quo;
    logic [DEN_W-1:0] sd_rem;
    logic             sd_done;

    seq_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W)) u_sdiv (
        .clk   (clk),
        .reset (reset),
        .start (sd_start),
        .num   (sd_num),
        .den   (sd_den),
        .quo   (sd_quo),
        .rem   (sd_rem),
        .done  (sd_done)
    );

    // CDF memory model with RD_LAT = 2 register stages
    logic [31:0]  cdf [256];
    logic [127:0] r_p0;

    function automatic logic [127:0] line_of(input int a);
        return {cdf[4*a+3], cdf[4*a+2], cdf[4*a+1], cdf[4*a]};
    endfunction

    always @(posedge clk) begin
        r_p0                <= line_of(int'(u_if.cdf_mem_rd_addr[5:0]));
        u_if.cdf_mem_rd_data <= r_p0;
    end

    // Observation log
    int           wt_cnt     = 0;
    int           done_cnt   = 0;
    int           dstart_cnt = 0;
    logic [15:0]  obs_addr [LOG_N];
    logic [127:0] obs_data [LOG_N];

    always @(negedge clk) begin
        if (u_if.sc_mem_wt_en) begin
            if (wt_cnt < LOG_N) begin
                obs_addr[wt_cnt] <= u_if.sc_mem_wt_addr;
                obs_data[wt_cnt] <= u_if.sc_mem_wt_data;
            end
            wt_cnt <= wt_cnt + 1;
        end
        if (u_if.div_sc_mem_wt_done) done_cnt <= done_cnt + 1;
        if (u_dut.u_div.start)       dstart_cnt <= dstart_cnt + 1;
    end

    typedef struct packed {
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t        exp_q [$];
    int         n_chk = 0;
    int         n_err = 0;
    int         rd_ptr = 0;
    int         scan_max;
    logic [7:0] got_map [256];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint cdf_min_model();
        for (int e = 0; e < 256; e++) if (cdf[e] != 0) return longint'(cdf[e]);
        return 0;
    endfunction

    function automatic logic [7:0] map_model(input int e, input longint cmin);
        longint c, den, q;
        c   = longint'(cdf[e]);
        den = TOTAL_PIX - cmin;
        if (c == 0 || c < cmin) return 8'd0;
        if (den == 0) return 8'd255;
        q = ((c - cmin) * 255) / den;
        if (q > 255) return 8'd255;
        return 8'(q);
    endfunction

    task automatic push_expected();
        longint cmin;
        wr_t    w;
        cmin = cdf_min_model();
        for (int l = 0; l < 64; l++) begin
            w.addr = 16'(l);
            w.data = '0;
            for (int s = 0; s < 4; s++) w.data[32*s +: 8] = map_model(4*l + s, cmin);
            exp_q.push_back(w);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        u_if.cdf_mem_wt_done = 1'b1;
        @(negedge clk);
        u_if.cdf_mem_wt_done = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int  base, wbase;
        bit  ok;
        base     = done_cnt;
        wbase    = wt_cnt;
        scan_max = 0;
        ok       = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (wt_cnt == wbase && int'(u_if.cdf_mem_rd_addr) > scan_max)
                scan_max = int'(u_if.cdf_mem_rd_addr);
            if (done_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 128'(ok), 128'(1));
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (wt_cnt - rd_ptr >= n) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_writes_reached"}, 128'(ok), 128'(1));
    endtask

    task automatic compare_writes(input string tag, input int n_expected);
        wr_t e;
        chk({tag, "_wcount"}, 128'(wt_cnt - rd_ptr), 128'(n_expected));
        while (rd_ptr < wt_cnt && rd_ptr < LOG_N && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_addr%0d", tag, e.addr), 128'(obs_addr[rd_ptr]), 128'(e.addr));
            chk($sformatf("%s_data%0d", tag, e.addr), obs_data[rd_ptr], e.data);
            for (int s = 0; s < 4; s++)
                got_map[4*int'(obs_addr[rd_ptr][5:0]) + s] = obs_data[rd_ptr][32*s +: 8];
            rd_ptr++;
        end
        rd_ptr = wt_cnt;
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_addr"}, 128'(u_if.cdf_mem_rd_addr), 128'(0));
        chk({tag, "_wt_addr"}, 128'(u_if.sc_mem_wt_addr), 128'(0));
        chk({tag, "_wt_data"}, u_if.sc_mem_wt_data, 128'(0));
        chk({tag, "_wt_en"}, 128'(u_if.sc_mem_wt_en), 128'(0));
        chk({tag, "_done"}, 128'(u_if.div_sc_mem_wt_done), 128'(0));
    endtask

    task automatic div_case(input string tag, input int n, input int d, input int q, input int r);
        int  cyc;
        bit  seen;
        @(negedge clk);
        sd_num   = NUM_W'(n);
        sd_den   = DEN_W'(d);
        sd_start = 1'b1;
        @(posedge clk); #1;
        sd_start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (sd_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_latency"}, 128'(seen ? cyc : -1), 128'(NUM_W));
        chk({tag, "_quo"}, 128'(sd_quo), 128'(q));
        chk({tag, "_rem"}, 128'(sd_rem), 128'(r));
    endtask

    task automatic load_uniform();
        for (int e = 0; e < 256; e++) cdf[e] = 32'(4 * (e + 1));
    endtask

    initial begin
        int base_done, base_ds;
        sd_start = 1'b0;
        sd_num   = '0;
        sd_den   = '0;
        u_if.cdf_mem_wt_done = 1'b0;
        load_uniform();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Standalone divider
        div_case("div_260100_1020", 260100, 1020, 255, 0);
        div_case("div_129540_1020", 129540, 1020, 127, 0);
        div_case("div_5_7", 5, 7, 0, 5);

        // Uniform CDF
        load_uniform();
        push_expected();
        base_done = done_cnt;
        start_pulse();
        wait_done("uniform", 10000);
        repeat (20) @(posedge clk);
        #1;
        compare_writes("uniform", 64);
        chk("uniform_done_count", 128'(done_cnt - base_done), 128'(1));
        chk("uniform_scan_max", 128'(scan_max), 128'(0));
        chk("uniform_map0", 128'(got_map[0]), 128'(0));
        chk("uniform_map1", 128'(got_map[1]), 128'(1));
        chk("uniform_map127", 128'(got_map[127]), 128'(127));
        chk("uniform_map255", 128'(got_map[255]), 128'(255));

        // Single-level image: den == 0 path, divider never started
        for (int e = 0; e < 256; e++) cdf[e] = (e < 100) ? 32'd0 : 32'd1024;
        push_expected();
        base_ds = dstart_cnt;
        start_pulse();
        wait_done("single", 10000);
        repeat (20) @(posedge clk);
        #1;
        compare_writes("single", 64);
        chk("single_div_starts", 128'(dstart_cnt - base_ds), 128'(0));
        chk("single_map99", 128'(got_map[99]), 128'(0));
        chk("single_map100", 128'(got_map[100]), 128'(255));
        chk("single_scan_max", 128'(scan_max), 128'(25));

        // Sparse CDF: first nonzero at line 5 slot 2
        for (int e = 0; e < 256; e++) cdf[e] = (e < 22) ? 32'd0 : 32'(37 + ((e - 22) * 987) / 233);
        push_expected();
        start_pulse();
        wait_done("sparse", 10000);
        repeat (20) @(posedge clk);
        #1;
        compare_writes("sparse", 64);
        chk("sparse_scan_max", 128'(scan_max), 128'(5));
        chk("sparse_map21", 128'(got_map[21]), 128'(0));
        chk("sparse_map22", 128'(got_map[22]), 128'(0));
        chk("sparse_map255", 128'(got_map[255]), 128'(255));

        // Reset during DIV_WAIT of line 30
        load_uniform();
        push_expected();
        base_done = done_cnt;
        start_pulse();
        wait_writes("abort", 30, 10000);
        begin
            bit in_wait;
            in_wait = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk); #1;
                if (u_dut.r_state == S_DIV_WAIT) begin
                    in_wait = 1'b1;
                    break;
                end
            end
            chk("abort_reached_div_wait", 128'(in_wait), 128'(1));
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("abort_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        compare_writes("abort", 30);
        chk("abort_no_done", 128'(done_cnt - base_done), 128'(0));

        // Fresh start after abort
        push_expected();
        base_done = done_cnt;
        start_pulse();
        wait_done("fresh", 10000);
        repeat (20) @(posedge clk);
        #1;
        compare_writes("fresh", 64);
        chk("fresh_done_count", 128'(done_cnt - base_done), 128'(1));

        // Second start pulse mid-run is ignored
        push_expected();
        base_done = done_cnt;
        start_pulse();
        wait_writes("dbl", 10, 10000);
        start_pulse();
        wait_done("dbl", 10000);
        repeat (200) @(posedge clk);
        #1;
        compare_writes("dbl", 64);
        chk("dbl_done_count", 128'(done_cnt - base_done), 128'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
